quiz_round_ctrl: RTL and testbench

- Consumer-side controller for the random operand generators: samples two 0..5 operands, presents an addition question, accepts one player answer per round, and judges and scores it.
- Runs a game of ROUNDS questions with a per-question timeout.
- Sits between the generator pair (upstream) and the display/keypad logic (downstream).
- Generators update on the falling clock edge; this block samples only on the rising edge.

---
 rtl/quiz_pkg.sv | 27 ++
 rtl/quiz_round_ctrl_if.sv | 44 ++++
 rtl/quiz_timer.sv | 37 +++
 rtl/quiz_round_ctrl.sv | 177 +++++++++++++++++
 tb/tb_quiz_round_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared widths, state/verdict enums and operand clamp for the quiz round controller
package quiz_pkg;

  localparam int OP_W  = 3;
  localparam int ANS_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ANS,
    RESULT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    V_CORRECT,
    V_WRONG,
    V_TIMEOUT
  } verdict_t;

  // Saturate a raw generator value to the largest legal operand
  function automatic logic [OP_W-1:0] clamp_op(input logic [OP_W-1:0] v,
                                               input logic [OP_W-1:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// rtl/quiz_round_ctrl_if.sv - generator/keypad/display bundle of the quiz round controller (op_sub under QUIZ_SUBTRACT_EN)
interface quiz_round_ctrl_if import quiz_pkg::*; ();

  logic             start;
  logic [OP_W-1:0]  rnd_a;
  logic [OP_W-1:0]  rnd_b;
  logic             ans_valid;
  logic [ANS_W-1:0] ans;

  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic             prompt_valid;
  logic             correct_pulse;
  logic             wrong_pulse;
  logic             timeout_pulse;
  logic [3:0]       score;
  logic [3:0]       round_idx;
  logic             busy;
  logic             done;
`ifdef QUIZ_SUBTRACT_EN
  logic             op_sub;
`endif

  // Environment side: generators, keypad and game start button
  modport master (
`ifdef QUIZ_SUBTRACT_EN
    input  op_sub,
`endif
    output start, rnd_a, rnd_b, ans_valid, ans,
    input  op_a, op_b, prompt_valid, correct_pulse, wrong_pulse, timeout_pulse,
    input  score, round_idx, busy, done
  );

  // Controller side
  modport slave (
`ifdef QUIZ_SUBTRACT_EN
    output op_sub,
`endif
    input  start, rnd_a, rnd_b, ans_valid, ans,
    output op_a, op_b, prompt_valid, correct_pulse, wrong_pulse, timeout_pulse,
    output score, round_idx, busy, done
  );

endinterface

// File: rtl/quiz_timer.sv
// rtl/quiz_timer.sv - loadable down-counter that parks at zero and flags expiry
module quiz_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; counting stops at zero so expiry stays asserted
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/quiz_round_ctrl.sv
// rtl/quiz_round_ctrl.sv - quiz game sequencer: operand sampling, answer judging, scoring; QUIZ_SUBTRACT_EN adds subtraction rounds
module quiz_round_ctrl import quiz_pkg::*; #(
  parameter int ROUNDS      = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int RESULT_CYC  = 4,
  parameter int OP_MAX      = 5
) (
  input logic             clk,
  input logic             rst,
  quiz_round_ctrl_if.slave bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RS_W = $clog2(RESULT_CYC + 1);

  localparam logic [3:0]      LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [3:0]      MAX_SCORE  = 4'(ROUNDS);
  localparam logic [OP_W-1:0] OP_MAX_V   = OP_W'(OP_MAX);
  localparam logic [TO_W-1:0] TO_LOAD    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RS_W-1:0] RS_LOAD    = RS_W'(RESULT_CYC - 1);

  state_t           state_q;
  logic [OP_W-1:0]  op_a_q;
  logic [OP_W-1:0]  op_b_q;
  logic             prompt_q;
  logic             correct_q;
  logic             wrong_q;
  logic             timeout_q;
  logic [3:0]       score_q;
  logic [3:0]       round_q;
  logic             busy_q;
  logic             done_q;
  logic             op_sub_q;

  logic [OP_W-1:0]  a_clamp;
  logic [OP_W-1:0]  b_clamp;
  logic [OP_W-1:0]  op_a_d;
  logic [OP_W-1:0]  op_b_d;
  logic             op_sub_d;
  logic [ANS_W-1:0] expect_ans;
  verdict_t         verdict_d;
  logic             verdict_now;
  logic             to_expired;
  logic             rs_expired;

  // Operand preparation for LOAD and answer judging for WAIT_ANS
  always_comb begin
    a_clamp  = clamp_op(bus.rnd_a, OP_MAX_V);
    b_clamp  = clamp_op(bus.rnd_b, OP_MAX_V);
    op_a_d   = a_clamp;
    op_b_d   = b_clamp;
    op_sub_d = 1'b0;
`ifdef QUIZ_SUBTRACT_EN
    op_sub_d = round_q[0];
    if (op_sub_d && (a_clamp < b_clamp)) begin
      op_a_d = b_clamp;
      op_b_d = a_clamp;
    end
    expect_ans = op_sub_q ? (ANS_W'(op_a_q) - ANS_W'(op_b_q))
                          : (ANS_W'(op_a_q) + ANS_W'(op_b_q));
`else
    expect_ans = ANS_W'(op_a_q) + ANS_W'(op_b_q);
`endif
    verdict_d = V_TIMEOUT;
    if (bus.ans_valid) begin
      verdict_d = (bus.ans == expect_ans) ? V_CORRECT : V_WRONG;
    end
    // An answer in the final timer cycle still takes this path, so it beats the timeout
    verdict_now = (state_q == WAIT_ANS) && (bus.ans_valid || to_expired);
  end

  quiz_timer #(.W(TO_W)) u_answer_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == LOAD),
    .load_val_i (TO_LOAD),
    .en_i       (state_q == WAIT_ANS),
    .expired_o  (to_expired)
  );

  quiz_timer #(.W(RS_W)) u_result_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (verdict_now),
    .load_val_i (RS_LOAD),
    .en_i       (state_q == RESULT),
    .expired_o  (rs_expired)
  );

  // Game FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      prompt_q  <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      timeout_q <= 1'b0;
      score_q   <= '0;
      round_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      op_sub_q  <= 1'b0;
    end else begin
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q  <= LOAD;
            score_q  <= '0;
            round_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            op_sub_q <= 1'b0;
          end
        end
        LOAD: begin
          op_a_q   <= op_a_d;
          op_b_q   <= op_b_d;
          op_sub_q <= op_sub_d;
          prompt_q <= 1'b1;
          state_q  <= WAIT_ANS;
        end
        WAIT_ANS: begin
          if (verdict_now) begin
            prompt_q <= 1'b0;
            state_q  <= RESULT;
            case (verdict_d)
              V_CORRECT: begin
                correct_q <= 1'b1;
                if (score_q != MAX_SCORE) begin
                  score_q <= score_q + 1'b1;
                end
              end
              V_WRONG:   wrong_q   <= 1'b1;
              default:   timeout_q <= 1'b1;
            endcase
          end
        end
        RESULT: begin
          if (rs_expired) begin
            if (round_q == LAST_ROUND) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              round_q <= round_q + 1'b1;
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.op_a          = op_a_q;
  assign bus.op_b          = op_b_q;
  assign bus.prompt_valid  = prompt_q;
  assign bus.correct_pulse = correct_q;
  assign bus.wrong_pulse   = wrong_q;
  assign bus.timeout_pulse = timeout_q;
  assign bus.score         = score_q;
  assign bus.round_idx     = round_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
`ifdef QUIZ_SUBTRACT_EN
  assign bus.op_sub        = op_sub_q;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub_q;
`endif

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb/tb_quiz_round_ctrl.sv - table-driven bench for quiz_round_ctrl
module tb_quiz_round_ctrl;
  import quiz_pkg::*;

  localparam int ROUNDS = 8;
  localparam int TO     = 1000;
  localparam int RC     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quiz_round_ctrl_if bus();

  quiz_round_ctrl #(
    .ROUNDS      (ROUNDS),
    .TIMEOUT_CYC (TO),
    .RESULT_CYC  (RC),
    .OP_MAX      (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    bit         give;
    int         delay;
    logic [3:0] ans;
    logic [2:0] ea;
    logic [2:0] eb;
    logic [2:0] ep;
    logic [3:0] es;
  } row_t;

  row_t rows[ROUNDS];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] pulses();
    return {bus.correct_pulse, bus.wrong_pulse, bus.timeout_pulse};
  endfunction

  task automatic wait_prompt(output int n);
    n = 0;
    while (!bus.prompt_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Called in the LOAD cycle of round i; returns in the cycle after RESULT ends
  task automatic run_row(input int i);
    row_t r;
    int   n;
    r = rows[i];
    bus.rnd_a = r.a;
    bus.rnd_b = r.b;
    wait_prompt(n);
    check($sformatf("r%0d prompt latency", i), n, 1);
    check($sformatf("r%0d op_a", i), bus.op_a, r.ea);
    check($sformatf("r%0d op_b", i), bus.op_b, r.eb);
    check($sformatf("r%0d round_idx", i), bus.round_idx, i);
`ifdef QUIZ_SUBTRACT_EN
    check($sformatf("r%0d op_sub", i), bus.op_sub, i % 2);
`endif
    if (r.give) begin
      repeat (r.delay) tick();
      bus.ans_valid = 1'b1;
      bus.ans       = r.ans;
      tick();
      bus.ans_valid = 1'b0;
    end else begin
      repeat (TO - 1) tick();
      check($sformatf("r%0d pre-expiry quiet", i), {bus.prompt_valid, pulses()}, 4'b1000);
      tick();
    end
    check($sformatf("r%0d verdict", i), pulses(), r.ep);
    check($sformatf("r%0d score", i), bus.score, r.es);
    check($sformatf("r%0d prompt off", i), bus.prompt_valid, 0);
    // A stray answer and a start during RESULT must change nothing
    bus.ans_valid = 1'b1;
    bus.ans       = r.ans;
    bus.start     = 1'b1;
    tick();
    bus.ans_valid = 1'b0;
    bus.start     = 1'b0;
    check($sformatf("r%0d ignored", i), {pulses(), bus.score, bus.busy}, {3'b000, r.es, 1'b1});
    tick();
    tick();
    check($sformatf("r%0d result hold", i), bus.round_idx, i);
    tick();
    if (i < ROUNDS - 1) begin
      check($sformatf("r%0d advance", i), {bus.round_idx, bus.busy}, {4'(i + 1), 1'b1});
    end else begin
      check("game done", {bus.done, bus.busy, bus.score, bus.round_idx}, {1'b1, 1'b0, 4'd5, 4'd7});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rows[0] = '{3'd3, 3'd4, 1'b1, 3,      4'd7,  3'd3, 3'd4, 3'b100, 4'd1};
`ifdef QUIZ_SUBTRACT_EN
    rows[1] = '{3'd2, 3'd5, 1'b1, 0,      4'd3,  3'd5, 3'd2, 3'b100, 4'd2};
`else
    rows[1] = '{3'd2, 3'd5, 1'b1, 0,      4'd7,  3'd2, 3'd5, 3'b100, 4'd2};
`endif
    rows[2] = '{3'd6, 3'd7, 1'b1, 1,      4'd10, 3'd5, 3'd5, 3'b100, 4'd3};
    rows[3] = '{3'd6, 3'd7, 1'b1, 2,      4'd9,  3'd5, 3'd5, 3'b010, 4'd3};
    rows[4] = '{3'd0, 3'd0, 1'b0, 0,      4'd0,  3'd0, 3'd0, 3'b001, 4'd3};
`ifdef QUIZ_SUBTRACT_EN
    rows[5] = '{3'd1, 3'd2, 1'b1, TO - 1, 4'd1,  3'd2, 3'd1, 3'b100, 4'd4};
`else
    rows[5] = '{3'd1, 3'd2, 1'b1, TO - 1, 4'd3,  3'd1, 3'd2, 3'b100, 4'd4};
`endif
    rows[6] = '{3'd7, 3'd0, 1'b1, 0,      4'd15, 3'd5, 3'd0, 3'b010, 4'd4};
`ifdef QUIZ_SUBTRACT_EN
    rows[7] = '{3'd4, 3'd5, 1'b1, 4,      4'd1,  3'd5, 3'd4, 3'b100, 4'd5};
`else
    rows[7] = '{3'd4, 3'd5, 1'b1, 4,      4'd9,  3'd4, 3'd5, 3'b100, 4'd5};
`endif

    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.rnd_a     = 3'd0;
    bus.rnd_b     = 3'd0;
    bus.ans_valid = 1'b0;
    bus.ans       = 4'd0;
    repeat (3) tick();
    check("reset outputs",
          {bus.op_a, bus.op_b, bus.prompt_valid, pulses(), bus.score, bus.round_idx, bus.busy, bus.done}, 0);
`ifdef QUIZ_SUBTRACT_EN
    check("reset op_sub", bus.op_sub, 0);
`endif
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
    check("idle after reset", {bus.busy, bus.prompt_valid, bus.done}, 0);

    bus.rnd_a = 3'd3;
    bus.rnd_b = 3'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start -> LOAD", {bus.busy, bus.prompt_valid}, 2'b10);
    for (int i = 0; i < ROUNDS; i++) begin
      run_row(i);
    end

    tick();
    tick();
    check("done hold", {bus.done, bus.score, bus.round_idx, bus.op_a}, {1'b1, 4'd5, 4'd7, rows[7].ea});

    bus.rnd_a = 3'd3;
    bus.rnd_b = 3'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart clears", {bus.done, bus.score, bus.round_idx, bus.busy}, {1'b0, 4'd0, 4'd0, 1'b1});
    wait_prompt(n);
    check("restart prompt", {bus.prompt_valid, bus.op_a, bus.op_b}, {1'b1, 3'd3, 3'd4});

    tick();
    rst           = 1'b1;
    bus.ans_valid = 1'b1;
    bus.ans       = 4'd7;
    tick();
    check("rst mid-game", {bus.prompt_valid, pulses(), bus.score, bus.busy, bus.op_a}, 0);
    rst           = 1'b0;
    bus.ans_valid = 1'b0;
    tick();
    check("no late pulse", {pulses(), bus.busy, bus.done}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
